// File: rtl/vga_timing_pkg.sv
// Shared VGA timing description, 10-bit counter type and RGB565 expansion
// used by the frame-buffer display reader.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int DSIZE = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h_active;
    cnt_t h_fp;
    cnt_t h_sync;
    cnt_t h_bp;
    cnt_t v_active;
    cnt_t v_fp;
    cnt_t v_sync;
    cnt_t v_bp;
  } vga_timing_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_active: 10'd640, h_fp: 10'd16, h_sync: 10'd96, h_bp: 10'd48,
    v_active: 10'd480, v_fp: 10'd10, v_sync: 10'd2,  v_bp: 10'd33
  };

  function automatic cnt_t h_total(input vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic cnt_t v_total(input vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  function automatic cnt_t hs_start(input vga_timing_t t);
    return t.h_active + t.h_fp;
  endfunction

  function automatic cnt_t hs_end(input vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync;
  endfunction

  function automatic cnt_t vs_start(input vga_timing_t t);
    return t.v_active + t.v_fp;
  endfunction

  function automatic cnt_t vs_end(input vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync;
  endfunction

  localparam cnt_t H_TOTAL  = h_total(VGA_640X480);
  localparam cnt_t V_TOTAL  = v_total(VGA_640X480);
  localparam cnt_t HS_START = hs_start(VGA_640X480);
  localparam cnt_t HS_END   = hs_end(VGA_640X480);
  localparam cnt_t VS_START = vs_start(VGA_640X480);
  localparam cnt_t VS_END   = vs_end(VGA_640X480);

  // Replicate the MSBs into the new LSBs so full-scale maps to 8'hFF.
  function automatic rgb888_t rgb565_to_888(input logic [15:0] d);
    rgb888_t p;
    p.r = {d[15:11], d[15:13]};
    p.g = {d[10:5],  d[10:9]};
    p.b = {d[4:0],   d[4:2]};
    return p;
  endfunction

endpackage

// File: rtl/sdram_vga_reader_if.sv
// Read-port bundle between the display reader and the SDRAM controller's RD1 FIFO.
interface sdram_vga_reader_if #(
  parameter int DSIZE = 16
);
  logic             RD_REQ;
  logic             RD_LOAD;
  logic [DSIZE-1:0] RD_DATA;

  modport master (output RD_REQ, output RD_LOAD, input RD_DATA);
  modport slave  (input RD_REQ, input RD_LOAD, output RD_DATA);
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running H/V counters with region decode, raw (undelayed) syncs,
// active flag and a strobe on the last pixel of the frame.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_640X480
) (
  input  logic CLK,
  input  logic RESET_N,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic frame_end
);

  localparam cnt_t H_LAST = h_total(TIMING) - cnt_t'(1);
  localparam cnt_t V_LAST = v_total(TIMING) - cnt_t'(1);
  localparam cnt_t HS0    = hs_start(TIMING);
  localparam cnt_t HS1    = hs_end(TIMING);
  localparam cnt_t VS0    = vs_start(TIMING);
  localparam cnt_t VS1    = vs_end(TIMING);
  localparam cnt_t H_ACT  = TIMING.h_active;
  localparam cnt_t V_ACT  = TIMING.v_active;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n      = !((h_cnt >= HS0) && (h_cnt < HS1));
  assign vs_n      = !((v_cnt >= VS0) && (v_cnt < VS1));
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/sdram_vga_reader.sv
// VGA scan-out from the SDRAM read FIFO: per-pixel requests, per-frame reload,
// and a two-stage pipeline that keeps syncs/coordinates aligned with colour.
module sdram_vga_reader
  import vga_timing_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_640X480
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     FRAME_EN,
  sdram_vga_reader_if.master       rd,
  output logic                     VGA_HS,
  output logic                     VGA_VS,
  output logic                     VGA_BLANK_N,
  output logic [7:0]               VGA_R,
  output logic [7:0]               VGA_G,
  output logic [7:0]               VGA_B,
  output cnt_t                     PIX_X,
  output cnt_t                     PIX_Y
);

  localparam cnt_t V_ACT = TIMING.v_active;

  cnt_t    h_cnt, v_cnt;
  logic    active, hs_n, vs_n, frame_end;
  logic    run;
  logic    rd_req_q, rd_load_q;
  logic    hs_q1, vs_q1;
  cnt_t    x_q1, y_q1;
  rgb888_t pix;

  vga_sync_gen #(.TIMING(TIMING)) u_sync (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hs_n      (hs_n),
    .vs_n      (vs_n),
    .frame_end (frame_end)
  );

  // Enable is only honoured at the frame boundary so a frame is never torn.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       run <= 1'b0;
    else if (frame_end) run <= FRAME_EN;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_req_q  <= 1'b0;
      rd_load_q <= 1'b1;
      hs_q1     <= 1'b1;
      vs_q1     <= 1'b1;
      x_q1      <= '0;
      y_q1      <= '0;
    end else begin
      rd_req_q  <= active && run;
      rd_load_q <= (v_cnt == V_ACT) || !run;
      hs_q1     <= hs_n;
      vs_q1     <= vs_n;
      x_q1      <= h_cnt;
      y_q1      <= v_cnt;
    end
  end

  assign rd.RD_REQ  = rd_req_q;
  assign rd.RD_LOAD = rd_load_q;
  assign pix        = rgb565_to_888(rd.RD_DATA);

  // The issued request doubles as the delayed (active && run) visibility flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
    end else begin
      VGA_HS      <= hs_q1;
      VGA_VS      <= vs_q1;
      VGA_BLANK_N <= rd_req_q;
      VGA_R       <= rd_req_q ? pix.r : 8'h00;
      VGA_G       <= rd_req_q ? pix.g : 8'h00;
      VGA_B       <= rd_req_q ? pix.b : 8'h00;
      PIX_X       <= x_q1;
      PIX_Y       <= y_q1;
    end
  end

endmodule

// File: tb/tb_sdram_vga_reader.sv
// Directed bench for sdram_vga_reader on a shrunken raster; acts as the read FIFO
// and scoreboards every returned word against the displayed pixel.
module tb_sdram_vga_reader;
  import vga_timing_pkg::*;

  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 3, HT = HA + HFP + HSY + HBP;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  localparam vga_timing_t TB_T = '{
    h_active: cnt_t'(HA), h_fp: cnt_t'(HFP), h_sync: cnt_t'(HSY), h_bp: cnt_t'(HBP),
    v_active: cnt_t'(VA), v_fp: cnt_t'(VFP), v_sync: cnt_t'(VSY), v_bp: cnt_t'(VBP)
  };

  logic       CLK = 1'b0;
  logic       RESET_N, FRAME_EN;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  cnt_t       PIX_X, PIX_Y;

  sdram_vga_reader_if #(.DSIZE(16)) rd_if ();

  sdram_vga_reader #(.TIMING(TB_T)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .FRAME_EN    (FRAME_EN),
    .rd          (rd_if),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit v; int c; bit r; } hent_t;
  typedef struct { logic [7:0] r, g, b; int x, y; bit marker; } exp_t;

  int    tests = 0, fails = 0;
  exp_t  sb[$];
  hent_t h1, h2;
  int    c, idx, pat;
  bit    r;
  int    req_cnt, load_cnt, hs_lo, vs_lo, blank_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] x5(input logic [4:0] v);
    logic [7:0] t = 8'(v);
    return (t << 3) | (t >> 2);
  endfunction

  function automatic logic [7:0] x6(input logic [5:0] v);
    logic [7:0] t = 8'(v);
    return (t << 2) | (t >> 4);
  endfunction

  task automatic check_reset(input string pfx);
    chk({pfx, "_rd_req"},  rd_if.RD_REQ,  0);
    chk({pfx, "_rd_load"}, rd_if.RD_LOAD, 1);
    chk({pfx, "_hs"},      VGA_HS,        1);
    chk({pfx, "_vs"},      VGA_VS,        1);
    chk({pfx, "_blank_n"}, VGA_BLANK_N,   0);
    chk({pfx, "_rgb"},     {VGA_R, VGA_G, VGA_B}, 0);
    chk({pfx, "_pix_x"},   PIX_X,         0);
    chk({pfx, "_pix_y"},   PIX_Y,         0);
  endtask

  task automatic model_reset();
    c = 0; r = 0; idx = 0;
    h1 = '{0, 0, 0};
    h2 = '{0, 0, 0};
    sb.delete();
  endtask

  task automatic check_outputs();
    int h, v;
    bit act;
    exp_t e;
    logic [15:0] d;
    h = h1.c % HT; v = (h1.c / HT) % VT; act = (h < HA) && (v < VA);
    chk("rd_req",  rd_if.RD_REQ,  32'(act && h1.r));
    chk("rd_load", rd_if.RD_LOAD, 32'((v == VA) || !h1.r));
    if (!h2.v) begin
      chk("hs_early", VGA_HS, 1);
      chk("vs_early", VGA_VS, 1);
      chk("blank_early", VGA_BLANK_N, 0);
    end else begin
      h = h2.c % HT; v = (h2.c / HT) % VT; act = (h < HA) && (v < VA);
      chk("hs",      VGA_HS,      32'(!((h >= HA + HFP) && (h < HA + HFP + HSY))));
      chk("vs",      VGA_VS,      32'(!((v >= VA + VFP) && (v < VA + VFP + VSY))));
      chk("blank_n", VGA_BLANK_N, 32'(act && h2.r));
      chk("pix_x",   PIX_X,       h);
      chk("pix_y",   PIX_Y,       v);
    end
    if (VGA_BLANK_N === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_r", VGA_R, e.r);
        chk("sb_g", VGA_G, e.g);
        chk("sb_b", VGA_B, e.b);
        chk("sb_x", PIX_X, e.x);
        chk("sb_y", PIX_Y, e.y);
        if (e.marker) begin
          chk("marker_r",   VGA_R, 8'h10);
          chk("marker_g",   VGA_G, 8'h45);
          chk("marker_b",   VGA_B, 8'hA5);
          chk("marker_lat", h2.c % FT, 0);
        end
      end
    end else begin
      chk("blank_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    end
    // Read-FIFO model: data is presented in the cycle RD_REQ is high.
    if (rd_if.RD_REQ === 1'b1) begin
      case (pat)
        1:       d = 16'hF800;
        2:       d = 16'h07E0;
        3:       d = 16'h0010;
        default: d = (idx == 0) ? 16'h1234 : 16'($urandom);
      endcase
      e.r = x5(d[15:11]); e.g = x6(d[10:5]); e.b = x5(d[4:0]);
      e.x = idx % HA; e.y = idx / HA; e.marker = (pat == 0) && (idx == 0);
      sb.push_back(e);
      idx++;
      if (idx == HA * VA) idx = 0;
    end else begin
      d = 16'($urandom);
    end
    rd_if.RD_DATA = d;
  endtask

  task automatic tick();
    h2 = h1;
    h1 = '{1, c, r};
    if (c % FT == FT - 1) r = FRAME_EN;
    c++;
    @(negedge CLK);
    check_outputs();
    if (rd_if.RD_REQ === 1'b1)  req_cnt++;
    if (rd_if.RD_LOAD === 1'b1) load_cnt++;
    if (VGA_HS === 1'b0)        hs_lo++;
    if (VGA_VS === 1'b0)        vs_lo++;
    if (VGA_BLANK_N === 1'b1)   blank_hi++;
  endtask

  task automatic run_to(input int target);
    while (c < target) tick();
  endtask

  task automatic clr_stats();
    req_cnt = 0; load_cnt = 0; hs_lo = 0; vs_lo = 0; blank_hi = 0;
  endtask

  task automatic wait_blank();
    for (int i = 0; i < 2 * FT; i++) begin
      if (VGA_BLANK_N === 1'b1) break;
      tick();
    end
    chk("wait_blank", VGA_BLANK_N, 1);
  endtask

  initial begin
    RESET_N = 1'b0; FRAME_EN = 1'b0; rd_if.RD_DATA = '0; pat = 0;
    model_reset(); clr_stats();
    repeat (3) @(negedge CLK);
    check_reset("rst");

    // Frame 0 after reset is always dark, even with enable already high.
    RESET_N = 1'b1; FRAME_EN = 1'b1;
    run_to(FT);
    chk("f0_req",  req_cnt, 0);
    chk("f0_load", load_cnt, FT);

    clr_stats();
    run_to(2 * FT);
    chk("f1_req",   req_cnt,  HA * VA);
    chk("f1_load",  load_cnt, HT);
    chk("f1_hs_lo", hs_lo,    VT * HSY);
    chk("f1_vs_lo", vs_lo,    VSY * HT);
    chk("f1_blank", blank_hi, HA * VA);

    pat = 1;
    run_to(2 * FT + HT);
    wait_blank();
    chk("red_r", VGA_R, 8'hFF); chk("red_g", VGA_G, 8'h00); chk("red_b", VGA_B, 8'h00);
    pat = 2;
    repeat (HT) tick();
    chk("grn_r", VGA_R, 8'h00); chk("grn_g", VGA_G, 8'hFF); chk("grn_b", VGA_B, 8'h00);
    pat = 3;
    repeat (HT) tick();
    chk("blu_r", VGA_R, 8'h00); chk("blu_g", VGA_G, 8'h00); chk("blu_b", VGA_B, 8'h84);
    pat = 0;

    run_to(3 * FT + 2 * HT);
    FRAME_EN = 1'b0;
    clr_stats();
    run_to(4 * FT);
    chk("f3_req_after_drop", req_cnt, (VA - 2) * HA);

    clr_stats();
    run_to(5 * FT);
    chk("f4_req",   req_cnt,  0);
    chk("f4_load",  load_cnt, FT);
    chk("f4_blank", blank_hi, 0);
    chk("f4_hs_lo", hs_lo,    VT * HSY);
    chk("f4_vs_lo", vs_lo,    VSY * HT);

    FRAME_EN = 1'b1;
    run_to(6 * FT + 3 * HT + 5);
    chk("pre_reset_blank", VGA_BLANK_N, 1);
    #3 RESET_N = 1'b0;
    #1 check_reset("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset(); clr_stats();

    run_to(FT);
    chk("rr_f0_req", req_cnt, 0);
    clr_stats();
    run_to(2 * FT);
    chk("rr_f1_req",  req_cnt,  HA * VA);
    chk("rr_f1_load", load_cnt, HT);
    chk("sb_drain",   sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
